// File: rtl/tvp_config_seq.sv
// tvp_config_seq: TVP decoder reset/power-up and I2C register-table configuration sequencer
module tvp_config_seq #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W = 5,
  parameter logic [6:0] DEV_ADDR = 7'h5C,
  parameter int RST_CYC = 400,
  parameter int PWR_CYC = 400000,
  parameter int GAP_CYC = 200,
  parameter int TIMEOUT_CYC = 100000,
  parameter int MAX_RETRY = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_tbl_addr,
  input  logic [15:0]       i_tbl_data,
  output logic              o_i2c_req,
  output logic [6:0]        o_i2c_dev,
  output logic [7:0]        o_i2c_reg,
  output logic [7:0]        o_i2c_data,
  input  logic              i_i2c_busy,
  input  logic              i_i2c_done,
  input  logic              i_i2c_nack,
  output logic              o_tvp_reset_n,
  output logic              o_cfg_busy,
  output logic              o_cfg_done,
  output logic              o_cfg_error,
  output logic [ADDR_W-1:0] o_cfg_err_idx
);
  localparam int MAX_A = PWR_CYC > TIMEOUT_CYC ? PWR_CYC : TIMEOUT_CYC;
  localparam int MAX_B = RST_CYC > GAP_CYC ? RST_CYC : GAP_CYC;
  localparam int CNT_W = $clog2((MAX_A > MAX_B ? MAX_A : MAX_B) + 1);
  localparam int RTY_W = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  typedef enum logic [2:0] {RST_ASSERT, PWR_WAIT, FETCH, ISSUE, WAIT_ACK, GAP, DONE, ERROR} state_t;
  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [RTY_W-1:0]  r_retry, w_retry;
  logic              r_again, w_again;
  logic              r_rst_n, w_rst_n;
  logic              r_req, w_req;
  logic [7:0]        r_reg, w_reg;
  logic [7:0]        r_data, w_data;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic [ADDR_W-1:0] r_err_idx, w_err_idx;
  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_state   <= RST_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_retry   <= '0;
      r_again   <= 1'b0;
      r_rst_n   <= 1'b0;
      r_req     <= 1'b0;
      r_reg     <= '0;
      r_data    <= '0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_retry   <= w_retry;
      r_again   <= w_again;
      r_rst_n   <= w_rst_n;
      r_req     <= w_req;
      r_reg     <= w_reg;
      r_data    <= w_data;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_err     <= w_err;
      r_err_idx <= w_err_idx;
    end
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt + 1'b1;
    w_idx     = r_idx;
    w_retry   = r_retry;
    w_again   = r_again;
    w_rst_n   = r_rst_n;
    w_req     = 1'b0;
    w_reg     = r_reg;
    w_data    = r_data;
    w_busy    = r_busy;
    w_done    = r_done;
    w_err     = r_err;
    w_err_idx = r_err_idx;
    case (r_state)
      RST_ASSERT:
        if (r_cnt == CNT_W'(RST_CYC - 1)) begin
          w_state = PWR_WAIT;
          w_cnt   = '0;
          w_rst_n = 1'b1;
        end
      PWR_WAIT:
        if (r_cnt == CNT_W'(PWR_CYC - 1)) begin
          w_state = FETCH;
          w_cnt   = '0;
        end
      FETCH:
        if (r_cnt != '0) begin
          w_cnt  = '0;
          w_reg  = i_tbl_data[15:8];
          w_data = i_tbl_data[7:0];
          w_state = i_tbl_data == 16'hFFFF ? DONE : ISSUE;
          w_done = i_tbl_data == 16'hFFFF;
          w_busy = i_tbl_data != 16'hFFFF;
        end
      ISSUE: begin
        w_cnt = '0;
        if (!i_i2c_busy) begin
          w_req   = 1'b1;
          w_state = WAIT_ACK;
        end
      end
      WAIT_ACK:
        if (i_i2c_done && !i_i2c_nack) begin
          w_cnt   = '0;
          w_retry = '0;
          w_again = 1'b0;
          if (r_idx == ADDR_W'(NUM_REGS - 1)) begin
            w_state = DONE;
            w_done  = 1'b1;
            w_busy  = 1'b0;
          end else begin
            w_idx   = r_idx + 1'b1;
            w_state = GAP;
          end
        end else if (i_i2c_done || r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_cnt = '0;
          if (r_retry < RTY_W'(MAX_RETRY)) begin
            w_retry = r_retry + 1'b1;
            w_again = 1'b1;
            w_state = GAP;
          end else begin
            w_state   = ERROR;
            w_err     = 1'b1;
            w_err_idx = r_idx;
            w_busy    = 1'b0;
          end
        end
      GAP:
        if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
          w_cnt   = '0;
          w_state = r_again ? ISSUE : FETCH;
        end
      default: begin
        w_cnt = '0;
        if (i_start) begin
          w_state   = RST_ASSERT;
          w_idx     = '0;
          w_retry   = '0;
          w_again   = 1'b0;
          w_rst_n   = 1'b0;
          w_busy    = 1'b1;
          w_done    = 1'b0;
          w_err     = 1'b0;
          w_err_idx = '0;
        end
      end
    endcase
  end
  assign o_tbl_addr    = r_idx;
  assign o_i2c_req     = r_req;
  assign o_i2c_dev     = DEV_ADDR;
  assign o_i2c_reg     = r_reg;
  assign o_i2c_data    = r_data;
  assign o_tvp_reset_n = r_rst_n;
  assign o_cfg_busy    = r_busy;
  assign o_cfg_done    = r_done;
  assign o_cfg_error   = r_err;
  assign o_cfg_err_idx = r_err_idx;
endmodule

// File: tb/tb_tvp_config_seq.sv
// tb_tvp_config_seq: directed self-checking bench for tvp_config_seq with a byte-level I2C master model
module tb_tvp_config_seq;
  localparam int NR = 4, AW = 5, RC = 40, PC = 300, GC = 20, TC = 200, MR = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_reset = 1'b1, i_start = 1'b0, i_i2c_busy = 1'b0, i_i2c_done = 1'b0, i_i2c_nack = 1'b0;
  logic [15:0] i_tbl_data = '0;
  logic [AW-1:0] o_tbl_addr, o_cfg_err_idx;
  logic o_i2c_req, o_tvp_reset_n, o_cfg_busy, o_cfg_done, o_cfg_error;
  logic [6:0] o_i2c_dev;
  logic [7:0] o_i2c_reg, o_i2c_data;
  logic [15:0] rom [32];
  logic [7:0] exp_reg [4] = '{8'h00, 8'h03, 8'h0D, 8'h0F};
  logic [7:0] exp_data [4] = '{8'h00, 8'h6F, 8'h47, 8'h2A};
  int n_tests = 0, n_fail = 0, cyc = 0;
  int req_cnt = 0, stab_err = 0, pend = 0, nack_entry = -1, nack_left = 0;
  logic [7:0] req_reg [64], req_data [64], cur_reg, cur_data;
  int req_cyc [64];
  logic pend_nack = 1'b0, silent = 1'b0;
  tvp_config_seq #(.NUM_REGS(NR), .ADDR_W(AW), .DEV_ADDR(7'h5C), .RST_CYC(RC), .PWR_CYC(PC),
                   .GAP_CYC(GC), .TIMEOUT_CYC(TC), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .o_tbl_addr(o_tbl_addr), .i_tbl_data(i_tbl_data),
    .o_i2c_req(o_i2c_req), .o_i2c_dev(o_i2c_dev), .o_i2c_reg(o_i2c_reg), .o_i2c_data(o_i2c_data),
    .i_i2c_busy(i_i2c_busy), .i_i2c_done(i_i2c_done), .i_i2c_nack(i_i2c_nack), .o_tvp_reset_n(o_tvp_reset_n),
    .o_cfg_busy(o_cfg_busy), .o_cfg_done(o_cfg_done), .o_cfg_error(o_cfg_error), .o_cfg_err_idx(o_cfg_err_idx)
  );
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    i_tbl_data = rom[o_tbl_addr];
    i_i2c_done = 1'b0;
    i_i2c_nack = 1'b0;
    if (i_reset) pend = 0;
    if (pend > 0) begin
      if (o_i2c_reg !== cur_reg || o_i2c_data !== cur_data) stab_err++;
      pend--;
      if (pend == 0) begin
        i_i2c_done = 1'b1;
        i_i2c_nack = pend_nack;
      end
    end
    if (o_i2c_req === 1'b1) begin
      if (req_cnt < 64) begin
        req_reg[req_cnt] = o_i2c_reg;
        req_data[req_cnt] = o_i2c_data;
        req_cyc[req_cnt] = cyc;
      end
      req_cnt++;
      cur_reg = o_i2c_reg;
      cur_data = o_i2c_data;
      pend = silent ? 0 : 50;
      pend_nack = (int'(o_tbl_addr) == nack_entry) && nack_left > 0;
      if (pend_nack && nack_left < 255) nack_left--;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic wait_idle(input int bound, output bit ok);
    int n = 0;
    while (o_cfg_busy !== 1'b0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = o_cfg_busy === 1'b0;
  endtask
  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask
  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (o_tvp_reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_tvp_n: got %b want 0", o_tvp_reset_n); end
    n_tests++; if ({o_i2c_req, o_i2c_reg, o_i2c_data} !== 17'h0) begin n_fail++; $display("FAIL reset_i2c: got %b/%h/%h want 0/00/00", o_i2c_req, o_i2c_reg, o_i2c_data); end
    n_tests++; if (o_tbl_addr !== 5'd0) begin n_fail++; $display("FAIL reset_tbl_addr: got %0d want 0", o_tbl_addr); end
    n_tests++; if ({o_cfg_busy, o_cfg_done, o_cfg_error} !== 3'b100) begin n_fail++; $display("FAIL reset_flags: got %b want 100", {o_cfg_busy, o_cfg_done, o_cfg_error}); end
    n_tests++; if (o_cfg_err_idx !== 5'd0) begin n_fail++; $display("FAIL reset_err_idx: got %0d want 0", o_cfg_err_idx); end
    n_tests++; if (o_i2c_dev !== 7'h5C) begin n_fail++; $display("FAIL i2c_dev: got %h want 5c", o_i2c_dev); end
  endtask
  task automatic test_power_up();
    int n = 0, t0;
    bit ok;
    req_cnt = 0;
    i_reset = 1'b0;
    while (o_tvp_reset_n !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_tests++; if (n != RC) begin n_fail++; $display("FAIL rst_low_cycles: got %0d want %0d", n, RC); end
    t0 = cyc;
    n = 0;
    while (req_cnt == 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_tests++; if (req_cnt == 0 || req_cyc[0] - t0 < PC) begin n_fail++; $display("FAIL pwr_wait: got %0d cycles want >= %0d", req_cnt == 0 ? n : req_cyc[0] - t0, PC); end
    wait_idle(5000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL seq_finish: got busy want idle"); end
    n_tests++; if (req_cnt != 4) begin n_fail++; $display("FAIL req_count: got %0d want 4", req_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (req_reg[i] !== exp_reg[i] || req_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL req_%0d: got %h/%h want %h/%h", i, req_reg[i], req_data[i], exp_reg[i], exp_data[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      n_tests++; if (req_cyc[i] - req_cyc[i-1] < GC) begin n_fail++; $display("FAIL gap_%0d: got %0d want >= %0d", i, req_cyc[i] - req_cyc[i-1], GC); end
    end
    n_tests++; if ({o_cfg_busy, o_cfg_done, o_cfg_error} !== 3'b010) begin n_fail++; $display("FAIL done_flags: got %b want 010", {o_cfg_busy, o_cfg_done, o_cfg_error}); end
    n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL reg_stable: got %0d changes want 0", stab_err); end
  endtask
  task automatic test_end_marker();
    bit ok;
    rom[2] = 16'hFFFF;
    req_cnt = 0;
    pulse_start();
    wait_idle(5000, ok);
    n_tests++; if (!ok || req_cnt != 2) begin n_fail++; $display("FAIL end_marker_reqs: got %0d want 2", req_cnt); end
    n_tests++; if ({o_cfg_done, o_cfg_error} !== 2'b10) begin n_fail++; $display("FAIL end_marker_flags: got %b want 10", {o_cfg_done, o_cfg_error}); end
    rom[2] = 16'h0D47;
  endtask
  task automatic test_nack_retry();
    bit ok;
    nack_entry = 1;
    nack_left = 2;
    req_cnt = 0;
    pulse_start();
    wait_idle(5000, ok);
    n_tests++; if (!ok || req_cnt != 6) begin n_fail++; $display("FAIL retry_reqs: got %0d want 6", req_cnt); end
    for (int i = 1; i < 4; i++) begin
      n_tests++; if (req_reg[i] !== 8'h03 || req_data[i] !== 8'h6F) begin n_fail++; $display("FAIL retry_req_%0d: got %h/%h want 03/6f", i, req_reg[i], req_data[i]); end
    end
    n_tests++; if (req_reg[4] !== 8'h0D) begin n_fail++; $display("FAIL retry_next: got %h want 0d", req_reg[4]); end
    n_tests++; if ({o_cfg_done, o_cfg_error} !== 2'b10) begin n_fail++; $display("FAIL retry_flags: got %b want 10", {o_cfg_done, o_cfg_error}); end
  endtask
  task automatic test_nack_fail();
    bit ok;
    nack_entry = 2;
    nack_left = 255;
    req_cnt = 0;
    pulse_start();
    wait_idle(5000, ok);
    n_tests++; if (!ok || req_cnt != 6) begin n_fail++; $display("FAIL nack_reqs: got %0d want 6", req_cnt); end
    n_tests++; if (req_reg[5] !== 8'h0D) begin n_fail++; $display("FAIL nack_last_reg: got %h want 0d", req_reg[5]); end
    n_tests++; if ({o_cfg_busy, o_cfg_done, o_cfg_error} !== 3'b001) begin n_fail++; $display("FAIL nack_flags: got %b want 001", {o_cfg_busy, o_cfg_done, o_cfg_error}); end
    n_tests++; if (o_cfg_err_idx !== 5'd2) begin n_fail++; $display("FAIL nack_err_idx: got %0d want 2", o_cfg_err_idx); end
    n_tests++; if (o_tvp_reset_n !== 1'b1) begin n_fail++; $display("FAIL err_tvp_n: got %b want 1", o_tvp_reset_n); end
    repeat (300) @(posedge clk);
    #1;
    n_tests++; if (req_cnt != 6) begin n_fail++; $display("FAIL err_quiet: got %0d want 6", req_cnt); end
    nack_left = 0;
    pulse_start();
    n_tests++; if ({o_tvp_reset_n, o_cfg_busy, o_cfg_done, o_cfg_error} !== 4'b0100) begin n_fail++; $display("FAIL restart: got %b want 0100", {o_tvp_reset_n, o_cfg_busy, o_cfg_done, o_cfg_error}); end
    n_tests++; if (o_cfg_err_idx !== 5'd0) begin n_fail++; $display("FAIL restart_err_idx: got %0d want 0", o_cfg_err_idx); end
    wait_idle(5000, ok);
    n_tests++; if (!ok || o_cfg_done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b want 1", o_cfg_done); end
  endtask
  task automatic test_timeout();
    bit ok;
    silent = 1'b1;
    req_cnt = 0;
    pulse_start();
    wait_idle(10000, ok);
    n_tests++; if (!ok || req_cnt != 4) begin n_fail++; $display("FAIL timeout_reqs: got %0d want 4", req_cnt); end
    n_tests++; if (req_cyc[1] - req_cyc[0] < TC + GC) begin n_fail++; $display("FAIL timeout_spacing: got %0d want >= %0d", req_cyc[1] - req_cyc[0], TC + GC); end
    n_tests++; if (o_cfg_error !== 1'b1 || o_cfg_err_idx !== 5'd0) begin n_fail++; $display("FAIL timeout_err: got %b/%0d want 1/0", o_cfg_error, o_cfg_err_idx); end
    silent = 1'b0;
  endtask
  task automatic test_busy_and_reset();
    int n = 0;
    bit ok;
    i_i2c_busy = 1'b1;
    req_cnt = 0;
    pulse_start();
    repeat (50) @(posedge clk);
    #1;
    pulse_start();
    n_tests++; if ({o_tvp_reset_n, o_cfg_busy} !== 2'b11) begin n_fail++; $display("FAIL start_ignored: got %b want 11", {o_tvp_reset_n, o_cfg_busy}); end
    repeat (950) @(posedge clk);
    #1;
    n_tests++; if (req_cnt != 0 || o_cfg_busy !== 1'b1) begin n_fail++; $display("FAIL busy_hold: got %0d reqs want 0", req_cnt); end
    i_i2c_busy = 1'b0;
    while (req_cnt == 0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_tests++; if (req_cnt != 1) begin n_fail++; $display("FAIL busy_release: got %0d reqs want 1", req_cnt); end
    repeat (10) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if ({o_i2c_req, o_tvp_reset_n, o_cfg_busy} !== 3'b001) begin n_fail++; $display("FAIL mid_reset: got %b want 001", {o_i2c_req, o_tvp_reset_n, o_cfg_busy}); end
    i_reset = 1'b0;
    wait_idle(5000, ok);
    n_tests++; if (!ok || req_cnt != 5 || o_cfg_done !== 1'b1) begin n_fail++; $display("FAIL post_reset: got %0d reqs done=%b want 5/1", req_cnt, o_cfg_done); end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 4; i++) rom[i] = {exp_reg[i], exp_data[i]};
    test_reset();
    test_power_up();
    test_end_marker();
    test_nack_retry();
    test_nack_fail();
    test_timeout();
    test_busy_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
